aes_sched: RTL and testbench

Round-robin scheduler that shares the single AES core among `NUM_REQ` label-encryption requesters (gate-evaluation lanes) in the garbled-circuit evaluator. It accepts one 128-bit label plus gate tag per transaction, drives the core's start/done handshake, and returns the ciphertext tagged with the requester index and gate id. A watchdog guards against a hung core so a requester is never left waiting.

---
 rtl/aes_sched_pkg.sv | 15 +
 rtl/aes_sched_rr_arbiter.sv | 48 ++++
 rtl/aes_sched.sv | 153 +++++++++++++++
 tb/tb_aes_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler: datapath width,
// requester-index width and the scheduler state encoding.
package aes_sched_pkg;

   localparam int AES_W = 128;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/aes_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index at or after ptr,
// wrapping around, and returns it both one-hot and as an index.
import aes_sched_pkg::*;

module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   localparam int DW = IDX_W + 1;

   logic [DW-1:0] dist_s;
   logic [DW-1:0] best_s;

   // Distance of each requester from the pointer; keep the closest requesting one.
   always_comb begin
      best_s    = DW'(NUM_REQ);
      grant_idx = '0;
      dist_s    = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (DW'(j) >= {1'b0, ptr}) begin
            dist_s = DW'(j) - {1'b0, ptr};
         end else begin
            dist_s = DW'(j) + DW'(NUM_REQ) - {1'b0, ptr};
         end
         if (req[j] && (dist_s < best_s)) begin
            best_s    = dist_s;
            grant_idx = IDX_W'(j);
         end else begin
            best_s    = best_s;
            grant_idx = grant_idx;
         end
      end
   end

   // One-hot form of the winner; all zero when nobody requests.
   always_comb begin
      grant = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         grant[j] = (best_s != DW'(NUM_REQ)) && (grant_idx == IDX_W'(j));
      end
   end

endmodule

// File: rtl/aes_sched.sv
// Shares one AES core among NUM_REQ label-encryption lanes. One transaction
// at a time: grant, start the core, wait for done (or watchdog expiry), hold
// the tagged result until the consumer takes it.
import aes_sched_pkg::*;

module aes_sched #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 13,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*AES_W-1:0] req_data,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     aes_start,
   output logic [AES_W-1:0]         aes_state_init,
   input  logic                     aes_done,
   input  logic [AES_W-1:0]         aes_state_final,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDX_W-1:0]         rsp_idx,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [AES_W-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic                     err,
   input  logic                     err_clr
);

   localparam int WD_W = $clog2(TIMEOUT) + 1;

   state_e            state_r, state_nxt_s;
   logic [IDX_W-1:0]  rr_ptr_r, ptr_nxt_s;
   logic [AES_W-1:0]  init_r, data_r, sel_data_s;
   logic [TAG_W-1:0]  tag_r, sel_tag_s;
   logic [IDX_W-1:0]  idx_r;
   logic              rsp_err_r, err_r;
   logic [WD_W-1:0]   wd_r;
   logic              stale_r;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]  grant_idx_s;
   logic              accept_s, expire_s, err_set_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // The grant has to follow req_valid in the same cycle (a lane may withdraw),
   // so req_ready is decoded from the registered state and the arbiter.
   assign req_ready      = (state_r == ST_IDLE) ? grant_s : '0;
   assign accept_s       = (state_r == ST_IDLE) && (|req_valid);
   assign aes_start      = (state_r == ST_ISSUE);
   assign rsp_valid      = (state_r == ST_RESP);
   assign aes_state_init = init_r;
   assign rsp_idx        = idx_r;
   assign rsp_tag        = tag_r;
   assign rsp_data       = data_r;
   assign rsp_err        = rsp_err_r;
   assign err            = err_r;

   // Watchdog fires on the BUSY cycle whose count would reach TIMEOUT-1.
   assign expire_s  = (state_r == ST_BUSY) && (wd_r == WD_W'(TIMEOUT - 2));
   // A done outside BUSY is an error unless it is the leftover of an op aborted by reset.
   assign err_set_s = (expire_s && !aes_done) ||
                      (aes_done && (state_r != ST_BUSY) && !stale_r);

   // Mux the granted lane's label and gate id; next round-robin pointer.
   always_comb begin
      sel_data_s = '0;
      sel_tag_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_s == IDX_W'(i)) begin
            sel_data_s = req_data[i*AES_W +: AES_W];
            sel_tag_s  = req_tag[i*TAG_W +: TAG_W];
         end else begin
            sel_data_s = sel_data_s;
            sel_tag_s  = sel_tag_s;
         end
      end
      if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_idx_s + IDX_W'(1);
      end
   end

   // Next-state logic of the transaction FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_ISSUE;
            else          state_nxt_s = ST_IDLE;
         end
         ST_ISSUE: state_nxt_s = ST_BUSY;
         ST_BUSY: begin
            if (aes_done || expire_s) state_nxt_s = ST_RESP;
            else                      state_nxt_s = ST_BUSY;
         end
         ST_RESP: begin
            if (rsp_ready) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_RESP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Transaction datapath: request latch, watchdog, result capture, error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r  <= '0;
         init_r    <= '0;
         tag_r     <= '0;
         idx_r     <= '0;
         data_r    <= '0;
         rsp_err_r <= 1'b0;
         err_r     <= 1'b0;
         wd_r      <= '0;
         stale_r   <= 1'b1;
      end else begin
         if (accept_s) begin
            init_r   <= sel_data_s;
            tag_r    <= sel_tag_s;
            idx_r    <= grant_idx_s;
            rr_ptr_r <= ptr_nxt_s;
         end
         if (state_r == ST_ISSUE)     wd_r <= '0;
         else if (state_r == ST_BUSY) wd_r <= wd_r + WD_W'(1);
         if ((state_r == ST_BUSY) && aes_done) begin
            data_r    <= aes_state_final;
            rsp_err_r <= 1'b0;
         end else if (expire_s) begin
            data_r    <= '0;
            rsp_err_r <= 1'b1;
         end
         if (err_set_s)    err_r <= 1'b1;
         else if (err_clr) err_r <= 1'b0;
         // The first start or the first stray done ends the post-reset window.
         if ((state_r == ST_ISSUE) || (aes_done && (state_r != ST_BUSY))) stale_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_sched.sv
// Scoreboard bench for aes_sched: the driver pushes the expected tagged result
// at each accept, a monitor pops and compares at every response handshake.
// The bench also plays the AES core (result = label ^ core_key after core_lat).
module tb_aes_sched;
   localparam int NUM_REQ = 2;
   localparam int TAG_W   = 13;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [1:0]       idx;
      logic [TAG_W-1:0] tag;
      logic [127:0]     data;
      logic             e;
   } exp_t;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*128-1:0]   req_data;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     aes_start;
   logic [127:0]             aes_state_init;
   logic                     aes_done;
   logic [127:0]             aes_state_final;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [1:0]               rsp_idx;
   logic [TAG_W-1:0]         rsp_tag;
   logic [127:0]             rsp_data;
   logic                     rsp_err;
   logic                     err;
   logic                     err_clr;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           core_lat = 0;
   logic [127:0] core_key = '0;
   bit           spur_req = 1'b0;
   logic [127:0] lab [NUM_REQ];
   logic [TAG_W-1:0] tg [NUM_REQ];
   exp_t         exp_q [$];
   int           m_ptr = 0;
   bit           m_err = 1'b0;
   int           last_r = -1;

   aes_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_tag(req_tag),
      .aes_start(aes_start), .aes_state_init(aes_state_init),
      .aes_done(aes_done), .aes_state_final(aes_state_final),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .err(err), .err_clr(err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran too long");
      $fatal(1);
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   // Round robin from the spec: first valid index at or after the pointer.
   function automatic int model_grant(input logic [NUM_REQ-1:0] vm, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (vm[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic drive_reqs(input logic [NUM_REQ-1:0] vm);
      req_valid = vm;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i*128 +: 128]     = lab[i];
         req_tag[i*TAG_W +: TAG_W]  = tg[i];
      end
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_ctl"}, 160'({req_ready, aes_start, rsp_valid, rsp_idx, rsp_tag, rsp_err, err, aes_state_init}), 160'(0));
      chk({name, "_data"}, 160'(rsp_data), 160'(0));
   endtask

   // Core emulator: samples the label at start, answers after core_lat cycles
   // (never when core_lat < 1); spur_req forces a stray done pulse.
   initial begin
      int cnt;
      logic [127:0] res;
      cnt = 0;
      res = '0;
      aes_done = 1'b0;
      aes_state_final = '0;
      forever begin
         @(negedge clk);
         if (aes_start) begin
            cnt = (core_lat > 0) ? core_lat : 0;
            res = aes_state_init ^ core_key;
         end
         @(posedge clk);
         #1;
         aes_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               aes_done = 1'b1;
               aes_state_final = res;
            end
         end
         if (spur_req) begin
            aes_done = 1'b1;
            aes_state_final = rnd128();
         end
      end
   end

   // Monitor: compare every accepted response against the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && exp_q.size() == 0) begin
            flag_fail("rsp_unexpected");
         end else if (rst_n && rsp_valid && rsp_ready) begin
            e = exp_q.pop_front();
            chk("rsp_idx", 160'(rsp_idx), 160'(e.idx));
            chk("rsp_tag", 160'(rsp_tag), 160'(e.tag));
            chk("rsp_data", 160'(rsp_data), 160'(e.data));
            chk("rsp_err", 160'(rsp_err), 160'(e.e));
         end
      end
   end

   // One complete transaction; returns #1 after the edge following the handshake.
   task automatic run_txn(input logic [NUM_REQ-1:0] vm, input int lat, input int hold);
      int g, t_acc, t_exp;
      bit got;
      exp_t e;
      logic [143:0] snap;
      core_lat = lat;
      drive_reqs(vm);
      g = model_grant(vm, m_ptr);
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         @(negedge clk);
         if (req_ready != '0) got = 1'b1;
      end
      chk("accept_seen", 160'(got), 160'(1));
      if (!got) return;
      t_acc = cyc;
      if (last_r >= 0) chk("accept_spacing", 160'(t_acc), 160'(last_r + 1));
      chk("grant_onehot", 160'(req_ready), 160'(1 << g));
      e.idx = 2'(g);
      e.tag = tg[g];
      e.e   = (lat < 1) || (lat > TIMEOUT - 1);
      e.data = e.e ? 128'h0 : (lab[g] ^ core_key);
      exp_q.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
      @(posedge clk);
      #1;
      lab[g] = rnd128();
      tg[g]  = TAG_W'($urandom);
      drive_reqs(vm);
      @(negedge clk);
      chk("start_after_accept", 160'({aes_start, req_ready}), 160'({1'b1, {NUM_REQ{1'b0}}}));
      got = 1'b0;
      for (int w = 0; w < TIMEOUT + 20 && !got; w++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
         else if (aes_start) flag_fail("start_repeated");
      end
      chk("rsp_seen", 160'(got), 160'(1));
      t_exp = e.e ? (t_acc + 1 + TIMEOUT) : (t_acc + 2 + lat);
      chk("rsp_latency", 160'(cyc), 160'(t_exp));
      snap = {rsp_idx, rsp_tag, rsp_data, rsp_err};
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk("rsp_stable", 160'({rsp_valid, rsp_idx, rsp_tag, rsp_data, rsp_err}), 160'({1'b1, snap}));
         chk("quiet_in_resp", 160'({req_ready, aes_start}), 160'(0));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      last_r = cyc - 1;
      if (e.e) m_err = 1'b1;
      chk("err_flag", 160'(err), 160'(m_err));
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   initial begin
      bit got;
      rst_n = 1'b1;
      req_valid = '0;
      req_data = '0;
      req_tag = '0;
      rsp_ready = 1'b0;
      err_clr = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         lab[i] = rnd128();
         tg[i]  = TAG_W'($urandom);
      end
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset_vals");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset("after_release");
      @(posedge clk);
      #1;

      // Single request with the known label and result.
      lab[0]   = 128'h00112233445566778899AABBCCDDEEFF;
      tg[0]    = 13'd5;
      core_key = 128'h00112233445566778899AABBCCDDEEFF ^ {16{8'hA5}};
      run_txn(2'b01, 12, 0);

      // Contention: both lanes always valid, grants must alternate.
      core_key = rnd128();
      repeat (4) run_txn(2'b11, 3 + $urandom_range(0, 5), 0);

      // Backpressure on the response port.
      run_txn(2'b10, 7, 10);

      // Done on the last legal cycle is a success.
      run_txn(2'b01, TIMEOUT - 1, 0);

      // Hung core: watchdog response, sticky err.
      run_txn(2'b01, -1, 2);
      req_valid = '0;
      last_r = -1;
      repeat (3) begin
         @(negedge clk);
         chk("err_sticky", 160'(err), 160'(1));
      end
      @(posedge clk);
      #1 pulse_clr();
      m_err = 1'b0;
      chk("err_cleared", 160'(err), 160'(0));

      // Stray done in IDLE.
      @(negedge clk) spur_req = 1'b1;
      @(negedge clk) spur_req = 1'b0;
      @(negedge clk);
      chk("spurious_err", 160'(err), 160'(1));
      repeat (3) begin
         @(negedge clk);
         chk("spurious_no_rsp", 160'(rsp_valid), 160'(0));
      end
      @(posedge clk);
      #1 pulse_clr();
      chk("spurious_clr", 160'(err), 160'(0));
      @(negedge clk) spur_req = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(negedge clk) spur_req = 1'b0;
      @(posedge clk);
      #1 err_clr = 1'b0;
      chk("set_beats_clr", 160'(err), 160'(1));
      pulse_clr();
      chk("final_clr", 160'(err), 160'(0));
      @(posedge clk);
      #1;

      // Randomized traffic.
      for (int n = 0; n < 10; n++) begin
         core_key = rnd128();
         run_txn(NUM_REQ'($urandom_range(1, 3)), $urandom_range(1, 20), $urandom_range(0, 3));
      end
      req_valid = '0;
      last_r = -1;

      // Reset in the middle of BUSY, then a late done from the aborted op.
      core_lat = -1;
      drive_reqs(2'b01);
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         @(negedge clk);
         if (req_ready != '0) got = 1'b1;
      end
      chk("rst_test_accept", 160'(got), 160'(1));
      @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_reset("mid_busy_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_ptr = 0;
      m_err = 1'b0;
      @(negedge clk) spur_req = 1'b1;
      @(negedge clk) spur_req = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk_reset("after_stray_done");
      end
      @(posedge clk);
      #1;
      core_key = rnd128();
      run_txn(2'b11, 4, 0);
      req_valid = '0;
      repeat (3) @(posedge clk);
      chk("queue_drained", 160'(exp_q.size()), 160'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
